// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaled up-counter time base feeding a PWM comparator.
// Period, compare and prescaler values sit behind shadow registers and move
// into the active set on an update event (counter wrap or software force).
module pwm_timebase #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 preload_en,
    input  logic                 psc_wr,
    input  logic [PSC_WIDTH-1:0] psc_din,
    input  logic                 period_wr,
    input  logic [WIDTH-1:0]     period_din,
    input  logic                 compare_wr,
    input  logic [WIDTH-1:0]     compare_din,
    input  logic                 force_update,
    output logic [WIDTH-1:0]     cnt_out,
    output logic [WIDTH-1:0]     period_out,
    output logic [WIDTH-1:0]     compare_out,
    output logic                 enable_out,
    output logic                 update_evt
);

    localparam logic [PSC_WIDTH-1:0] PSC_ONE = {{(PSC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]       CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0]     period_sh_q, period_sh_d;
    logic [WIDTH-1:0]     period_act_q, period_act_d;
    logic [WIDTH-1:0]     compare_sh_q, compare_sh_d;
    logic [WIDTH-1:0]     compare_act_q, compare_act_d;
    logic [PSC_WIDTH-1:0] psc_sh_q, psc_sh_d;
    logic [PSC_WIDTH-1:0] psc_act_q, psc_act_d;
    logic                 enable_q, enable_d;
    logic                 update_evt_q, update_evt_d;

    logic                 tick;
    logic                 wrap;
    logic                 update;
    logic [WIDTH:0]       cnt_inc;

    // Tick/wrap/update decode; increment kept one bit wider so period 2^WIDTH-1 cannot overflow
    always_comb begin
        tick    = enable && (psc_cnt_q == psc_act_q);
        cnt_inc = {1'b0, cnt_q} + CNT_ONE;
        wrap    = (period_act_q == '0) || (cnt_inc >= {1'b0, period_act_q});
        update  = (tick && wrap) || force_update;
    end

    // Prescaler and main counter next state; force clears both even while disabled
    always_comb begin
        cnt_d     = cnt_q;
        psc_cnt_d = psc_cnt_q;
        if (force_update) begin
            cnt_d     = '0;
            psc_cnt_d = '0;
        end else if (tick) begin
            psc_cnt_d = '0;
            cnt_d     = wrap ? '0 : cnt_inc[WIDTH-1:0];
        end else if (enable) begin
            psc_cnt_d = psc_cnt_q + PSC_ONE;
        end
    end

    // Shadow/active register next state; a write landing on an update bypasses the shadow
    always_comb begin
        period_sh_d   = period_wr  ? period_din  : period_sh_q;
        compare_sh_d  = compare_wr ? compare_din : compare_sh_q;
        psc_sh_d      = psc_wr     ? psc_din     : psc_sh_q;

        period_act_d  = period_act_q;
        if (period_wr && (update || !preload_en)) begin
            period_act_d = period_din;
        end else if (update) begin
            period_act_d = period_sh_q;
        end

        compare_act_d = compare_act_q;
        if (compare_wr && (update || !preload_en)) begin
            compare_act_d = compare_din;
        end else if (update) begin
            compare_act_d = compare_sh_q;
        end

        // Prescaler is always buffered: it only changes on an update
        psc_act_d = psc_act_q;
        if (update) begin
            psc_act_d = psc_wr ? psc_din : psc_sh_q;
        end

        enable_d     = enable;
        update_evt_d = update;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            psc_cnt_q     <= '0;
            period_sh_q   <= '0;
            period_act_q  <= '0;
            compare_sh_q  <= '0;
            compare_act_q <= '0;
            psc_sh_q      <= '0;
            psc_act_q     <= '0;
            enable_q      <= 1'b0;
            update_evt_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            psc_cnt_q     <= psc_cnt_d;
            period_sh_q   <= period_sh_d;
            period_act_q  <= period_act_d;
            compare_sh_q  <= compare_sh_d;
            compare_act_q <= compare_act_d;
            psc_sh_q      <= psc_sh_d;
            psc_act_q     <= psc_act_d;
            enable_q      <= enable_d;
            update_evt_q  <= update_evt_d;
        end
    end

    assign cnt_out     = cnt_q;
    assign period_out  = period_act_q;
    assign compare_out = compare_act_q;
    assign enable_out  = enable_q;
    assign update_evt  = update_evt_q;

endmodule
